// File: rtl/tim_pkg.sv
// tim_pkg: shared timer constants, capture record type, index-width helper and channel mode encodings.
package tim_pkg;
  localparam int TIM_CNT_W = 64;
  typedef struct packed {
    logic [TIM_CNT_W-1:0] result;
    logic edge_type;
`ifdef TIM_ARB_TIMESTAMP_EN
    logic [31:0] stamp;
`endif
  } cap_rec_t;
  typedef enum logic [2:0] {
    MODE_RISE = 3'b001,
    MODE_FALL = 3'b010,
    MODE_BOTH = 3'b011,
    MODE_HIGH_W = 3'b100,
    MODE_LOW_W = 3'b101
  } cap_mode_t;
  function automatic int chan_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tim_capture_arbiter_if.sv
// tim_capture_arbiter_if: record stream from the arbiter to the register/DMA front end (Out_Stamp with TIM_ARB_TIMESTAMP_EN).
interface tim_capture_arbiter_if import tim_pkg::*; #(parameter int NUM_CH = 4, parameter int CNT_W = TIM_CNT_W);
  logic Out_Valid;
  logic Out_Ready;
  logic [chan_w(NUM_CH)-1:0] Out_Chan;
  logic [CNT_W-1:0] Out_Result;
  logic Out_Edge;
`ifdef TIM_ARB_TIMESTAMP_EN
  logic [31:0] Out_Stamp;
  modport master (output Out_Valid, Out_Chan, Out_Result, Out_Edge, Out_Stamp, input Out_Ready);
  modport slave (input Out_Valid, Out_Chan, Out_Result, Out_Edge, Out_Stamp, output Out_Ready);
`else
  modport master (output Out_Valid, Out_Chan, Out_Result, Out_Edge, input Out_Ready);
  modport slave (input Out_Valid, Out_Chan, Out_Result, Out_Edge, output Out_Ready);
`endif
endinterface

// File: rtl/tim_rr_arbiter.sv
// tim_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module tim_rr_arbiter #(parameter int N = 4, parameter int W = 2) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic any
);
  logic found;
  int c;
  assign any = |req;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        gnt[c] = 1'b1;
        idx = W'(c);
      end
    end
  end
endmodule

// File: rtl/tim_capture_arbiter.sv
// tim_capture_arbiter: fair serialiser of capture-channel results onto one valid/ready stream (TIM_ARB_TIMESTAMP_EN adds stamps).
module tim_capture_arbiter import tim_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = TIM_CNT_W
) (
  input  logic Clk,
  input  logic Reset,
  input  logic [NUM_CH-1:0] Ch_Enable,
  input  logic [NUM_CH-1:0] Cap_Valid,
  input  logic [NUM_CH*CNT_W-1:0] Cap_Result,
  input  logic [NUM_CH-1:0] Cap_Edge,
  output logic [NUM_CH-1:0] Overrun,
  input  logic Overrun_Clear,
  tim_capture_arbiter_if.master res
);
  localparam int W = chan_w(NUM_CH);
  logic [NUM_CH-1:0] full, slot_edge, load, gnt, gnt_q;
  logic [CNT_W-1:0] slot_res [NUM_CH];
  logic [W-1:0] rr_ptr, idx;
  logic any, free, take;
`ifdef TIM_ARB_TIMESTAMP_EN
  logic [31:0] tstamp;
  logic [31:0] slot_stamp [NUM_CH];
`endif
  tim_rr_arbiter #(.N(NUM_CH), .W(W)) u_arb (.req(full), .ptr(rr_ptr), .gnt(gnt), .idx(idx), .any(any));
  assign load = Cap_Valid & Ch_Enable;
  assign free = !res.Out_Valid || res.Out_Ready;
  assign take = free && any;
  assign gnt_q = take ? gnt : '0;
  // A load into a slot being granted refills it without counting as an overrun.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      full <= '0;
      Overrun <= '0;
      rr_ptr <= '0;
      res.Out_Valid <= 1'b0;
      res.Out_Chan <= '0;
      res.Out_Result <= '0;
      res.Out_Edge <= 1'b0;
`ifdef TIM_ARB_TIMESTAMP_EN
      tstamp <= '0;
      res.Out_Stamp <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        full[i] <= load[i] | (full[i] & ~gnt_q[i]);
        Overrun[i] <= (load[i] & full[i] & ~gnt_q[i]) | (Overrun[i] & ~Overrun_Clear);
        if (load[i]) begin
          slot_res[i] <= Cap_Result[i*CNT_W +: CNT_W];
          slot_edge[i] <= Cap_Edge[i];
`ifdef TIM_ARB_TIMESTAMP_EN
          slot_stamp[i] <= tstamp;
`endif
        end
      end
`ifdef TIM_ARB_TIMESTAMP_EN
      tstamp <= tstamp + 32'd1;
`endif
      if (take) begin
        res.Out_Valid <= 1'b1;
        res.Out_Chan <= idx;
        res.Out_Result <= slot_res[idx];
        res.Out_Edge <= slot_edge[idx];
`ifdef TIM_ARB_TIMESTAMP_EN
        res.Out_Stamp <= slot_stamp[idx];
`endif
        rr_ptr <= (idx == W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
      end else if (free) begin
        res.Out_Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tim_capture_arbiter.sv
// tb_tim_capture_arbiter: directed scenario tests for tim_capture_arbiter with NUM_CH=4, CNT_W=64.
module tb_tim_capture_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] ch_enable, cap_valid, cap_edge, overrun;
  logic overrun_clear;
  logic [255:0] cap_result;
  int passed = 0;
  int total = 0;
  tim_capture_arbiter_if #(.NUM_CH(4), .CNT_W(64)) bus ();
  tim_capture_arbiter #(.NUM_CH(4), .CNT_W(64)) dut (
    .Clk(clk), .Reset(rst), .Ch_Enable(ch_enable), .Cap_Valid(cap_valid),
    .Cap_Result(cap_result), .Cap_Edge(cap_edge), .Overrun(overrun),
    .Overrun_Clear(overrun_clear), .res(bus)
  );
  always #5 clk = ~clk;
  wire [67:0] rec = {bus.Out_Valid, bus.Out_Chan, bus.Out_Edge, bus.Out_Result};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [63:0] v, input logic e);
    cap_valid[ch] = 1'b1;
    cap_result[ch*64 +: 64] = v;
    cap_edge[ch] = e;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (rec !== 68'h0) $display("FAIL reset_out got %h exp %h", rec, 68'h0);
    else passed++;
    total++;
    if (overrun !== 4'h0) $display("FAIL reset_overrun got %h exp %h", overrun, 4'h0);
    else passed++;
  endtask

  task automatic test_single;
    bus.Out_Ready = 1'b1;
    pulse(2, 64'h0000_0001_0000_0010, 1'b1);
    step();
    cap_valid = '0;
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL single_t1 got %b exp 0", bus.Out_Valid);
    else passed++;
    step();
    total++;
    if (rec !== {1'b1, 2'd2, 1'b1, 64'h0000_0001_0000_0010}) $display("FAIL single_rec got %h exp %h", rec, {1'b1, 2'd2, 1'b1, 64'h0000_0001_0000_0010});
    else passed++;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL single_drop got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 4; i++) pulse(i, 64'd100 + 64'(i), i[0]);
    step();
    cap_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (rec !== {1'b1, 2'(i), i[0], 64'd100 + 64'(i)}) $display("FAIL b2b_rec%0d got %h exp %h", i, rec, {1'b1, 2'(i), i[0], 64'd100 + 64'(i)});
      else passed++;
    end
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL b2b_idle got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  task automatic test_backpressure;
    int bad = 0;
    bus.Out_Ready = 1'b0;
    pulse(1, 64'hAB, 1'b0);
    step();
    cap_valid = '0;
    step();
    total++;
    if (rec !== {1'b1, 2'd1, 1'b0, 64'hAB}) $display("FAIL bp_first got %h exp %h", rec, {1'b1, 2'd1, 1'b0, 64'hAB});
    else passed++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rec !== {1'b1, 2'd1, 1'b0, 64'hAB}) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
    else passed++;
    bus.Out_Ready = 1'b1;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL bp_single_accept got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  task automatic test_overrun;
    bus.Out_Ready = 1'b0;
    pulse(0, 64'h11, 1'b0);
    step();
    cap_valid = '0;
    step();
    pulse(3, 64'd5, 1'b0);
    step();
    pulse(3, 64'd9, 1'b1);
    step();
    cap_valid = '0;
    total++;
    if ({overrun, bus.Out_Chan} !== {4'b1000, 2'd0}) $display("FAIL ovr_set got %h exp %h", {overrun, bus.Out_Chan}, {4'b1000, 2'd0});
    else passed++;
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    total++;
    if (overrun !== 4'b0000) $display("FAIL ovr_clear got %b exp 0000", overrun);
    else passed++;
    bus.Out_Ready = 1'b1;
    step();
    bus.Out_Ready = 1'b0;
    total++;
    if (rec !== {1'b1, 2'd3, 1'b1, 64'd9}) $display("FAIL ovr_newest got %h exp %h", rec, {1'b1, 2'd3, 1'b1, 64'd9});
    else passed++;
    pulse(2, 64'd20, 1'b0);
    step();
    pulse(2, 64'd21, 1'b0);
    overrun_clear = 1'b1;
    step();
    cap_valid = '0;
    overrun_clear = 1'b0;
    total++;
    if (overrun !== 4'b0100) $display("FAIL ovr_set_wins got %b exp 0100", overrun);
    else passed++;
    overrun_clear = 1'b1;
    step();
    overrun_clear = 1'b0;
    bus.Out_Ready = 1'b1;
    step();
    total++;
    if ({overrun, rec} !== {4'b0000, 1'b1, 2'd2, 1'b0, 64'd21}) $display("FAIL ovr_drain got %h exp %h", {overrun, rec}, {4'b0000, 1'b1, 2'd2, 1'b0, 64'd21});
    else passed++;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL ovr_idle got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  task automatic test_refill;
    bus.Out_Ready = 1'b1;
    pulse(0, 64'd6, 1'b0);
    step();
    pulse(0, 64'd7, 1'b1);
    step();
    cap_valid = '0;
    total++;
    if ({overrun, rec} !== {4'b0000, 1'b1, 2'd0, 1'b0, 64'd6}) $display("FAIL refill_old got %h exp %h", {overrun, rec}, {4'b0000, 1'b1, 2'd0, 1'b0, 64'd6});
    else passed++;
    step();
    total++;
    if ({overrun, rec} !== {4'b0000, 1'b1, 2'd0, 1'b1, 64'd7}) $display("FAIL refill_new got %h exp %h", {overrun, rec}, {4'b0000, 1'b1, 2'd0, 1'b1, 64'd7});
    else passed++;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL refill_idle got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  task automatic test_mask_reset;
    ch_enable = 4'b1101;
    pulse(1, 64'h55, 1'b1);
    step();
    cap_valid = '0;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL mask_t2 got %b exp 0", bus.Out_Valid);
    else passed++;
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL mask_t3 got %b exp 0", bus.Out_Valid);
    else passed++;
    ch_enable = 4'b1111;
    bus.Out_Ready = 1'b0;
    pulse(0, 64'h1, 1'b0);
    pulse(1, 64'h2, 1'b0);
    step();
    cap_valid = '0;
    step();
    total++;
    if (bus.Out_Valid !== 1'b1) $display("FAIL rst_pre got %b exp 1", bus.Out_Valid);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (rec !== 68'h0) $display("FAIL rst_mid got %h exp %h", rec, 68'h0);
    else passed++;
    bus.Out_Ready = 1'b1;
    step();
    step();
    total++;
    if (bus.Out_Valid !== 1'b0) $display("FAIL rst_slots_empty got %b exp 0", bus.Out_Valid);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    ch_enable = 4'b1111;
    cap_valid = '0;
    cap_edge = '0;
    cap_result = '0;
    overrun_clear = 1'b0;
    bus.Out_Ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overrun();
    test_refill();
    test_mask_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
